irq_vector_ctrl: RTL

- Parametrised interrupt/trap controller, successor to the fixed-map combinational address generator.
- Captures NMI, ECALL, EBREAK, timer and NUM_IRQ external lines into pending bits, and arbitrates them by fixed priority.
- Issues a registered vector address to the fetch stage with a req/ack handshake, and tracks the in-service state until the trap-return pulse.
- Sits between the peripheral IRQ lines / core trap decode and the PC-select mux.

---
 rtl/irq_vector_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/irq_vector_ctrl.sv
// irq_vector_ctrl: captures NMI, ECALL, EBREAK, timer and external interrupt
// lines into pending bits. It picks one winner by fixed priority and presents a
// registered vector to fetch using a req/ack handshake. It then tracks the
// handler as in service until the trap-return pulse arrives.
// Build option: define IRQ_VEC_LEVEL_EN to make tmr_irq and irq level-sensitive
// (pending mirrors the registered line level and ack does not clear it).
module irq_vector_ctrl #(
   parameter int unsigned       NUM_IRQ    = 8,
   parameter int unsigned       ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] NMI_VEC    = ADDR_W'(32'h10),
   parameter logic [ADDR_W-1:0] ECALL_VEC  = ADDR_W'(32'h20),
   parameter logic [ADDR_W-1:0] EBREAK_VEC = ADDR_W'(32'h30),
   parameter logic [ADDR_W-1:0] TMR_VEC    = ADDR_W'(32'h40),
   parameter logic [ADDR_W-1:0] INT_BASE   = ADDR_W'(32'h100),
   parameter logic [ADDR_W-1:0] INT_STRIDE = ADDR_W'(32'h10),
   localparam int unsigned      IDX_W      = $clog2(NUM_IRQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 nmi,
   input  logic                 ecall,
   input  logic                 ebreak,
   input  logic                 tmr_irq,
   input  logic [NUM_IRQ-1:0]   irq,
   input  logic [NUM_IRQ-1:0]   irq_mask,
   input  logic                 glb_en,
   input  logic                 int_ack,
   input  logic                 int_done,
   output logic                 int_req,
   output logic [ADDR_W-1:0]    int_addr,
   output logic [2:0]           int_src,
   output logic [IDX_W-1:0]     int_idx,
   output logic                 in_service,
   output logic [NUM_IRQ+3:0]   pending
);

   localparam int unsigned NSRC  = NUM_IRQ + 4;
   localparam int unsigned POS_W = $clog2(NSRC);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t              state_r, state_nx_s;
   logic                nmi_q_r, tmr_q_r;
   logic [NUM_IRQ-1:0]  irq_q_r;
   logic [NSRC-1:0]     pending_r;
   logic [POS_W-1:0]    win_pos_r;

   logic [NSRC-1:0]     elig_s, set_s, clr_s, pend_nx_s;
   logic                any_s;
   logic [POS_W-1:0]    win_pos_s, win_nx_s;
   logic [2:0]          win_src_s, src_nx_s;
   logic [IDX_W-1:0]    win_idx_s, idx_nx_s;
   logic [ADDR_W-1:0]   win_addr_s, addr_nx_s;
   logic                req_nx_s, svc_nx_s;

   assign pending = pending_r;

   // Eligibility masking and fixed-priority pick: lowest pending bit index wins (NMI is bit 0).
   always_comb begin
      elig_s    = pending_r & {irq_mask & {NUM_IRQ{glb_en}}, glb_en, glb_en, glb_en, 1'b1};
      any_s     = |elig_s;
      win_pos_s = {POS_W{1'b0}};
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (elig_s[i]) begin
            win_pos_s = POS_W'(i);
         end else begin
            win_pos_s = win_pos_s;
         end
      end
      if (win_pos_s < POS_W'(3'd4)) begin
         win_src_s = 3'(win_pos_s);
         win_idx_s = {IDX_W{1'b0}};
      end else begin
         win_src_s = 3'd4;
         win_idx_s = IDX_W'(win_pos_s - POS_W'(3'd4));
      end
      case (win_src_s)
         3'd0:    win_addr_s = NMI_VEC;
         3'd1:    win_addr_s = ECALL_VEC;
         3'd2:    win_addr_s = EBREAK_VEC;
         3'd3:    win_addr_s = TMR_VEC;
         default: win_addr_s = INT_BASE + ADDR_W'(win_idx_s) * INT_STRIDE;
      endcase
   end

   // Pending capture: new events set bits, the acknowledged winner is cleared, and a set wins over a clear.
   always_comb begin
      set_s     = {irq & ~irq_q_r, tmr_irq & ~tmr_q_r, ebreak, ecall, nmi & ~nmi_q_r};
      pend_nx_s = (pending_r & ~clr_s) | set_s;
`ifdef IRQ_VEC_LEVEL_EN
      pend_nx_s[NSRC-1:3] = {irq, tmr_irq};
`else
      pend_nx_s[NSRC-1:3] = pend_nx_s[NSRC-1:3];
`endif
   end

   // Handshake FSM: latch the winner in IDLE, hold it through REQ, then wait in SERVICE for trap return.
   always_comb begin
      state_nx_s = state_r;
      req_nx_s   = int_req;
      svc_nx_s   = in_service;
      addr_nx_s  = int_addr;
      src_nx_s   = int_src;
      idx_nx_s   = int_idx;
      win_nx_s   = win_pos_r;
      clr_s      = {NSRC{1'b0}};
      case (state_r)
         IDLE: begin
            if (any_s) begin
               state_nx_s = REQ;
               req_nx_s   = 1'b1;
               addr_nx_s  = win_addr_s;
               src_nx_s   = win_src_s;
               idx_nx_s   = win_idx_s;
               win_nx_s   = win_pos_s;
            end else begin
               state_nx_s = IDLE;
            end
         end
         REQ: begin
            if (int_ack) begin
               clr_s[win_pos_r] = 1'b1;
               req_nx_s         = 1'b0;
               svc_nx_s         = 1'b1;
               state_nx_s       = SERVICE;
            end else begin
               state_nx_s = REQ;
            end
         end
         SERVICE: begin
            if (int_done) begin
               svc_nx_s   = 1'b0;
               state_nx_s = IDLE;
            end else begin
               state_nx_s = SERVICE;
            end
         end
         default: begin
            state_nx_s = IDLE;
            req_nx_s   = 1'b0;
            svc_nx_s   = 1'b0;
         end
      endcase
   end

   // State, outputs, pending bits and line samples; everything drops on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         nmi_q_r    <= 1'b0;
         tmr_q_r    <= 1'b0;
         irq_q_r    <= {NUM_IRQ{1'b0}};
         pending_r  <= {NSRC{1'b0}};
         win_pos_r  <= {POS_W{1'b0}};
         int_req    <= 1'b0;
         int_addr   <= {ADDR_W{1'b0}};
         int_src    <= 3'd0;
         int_idx    <= {IDX_W{1'b0}};
         in_service <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         nmi_q_r    <= nmi;
         tmr_q_r    <= tmr_irq;
         irq_q_r    <= irq;
         pending_r  <= pend_nx_s;
         win_pos_r  <= win_nx_s;
         int_req    <= req_nx_s;
         int_addr   <= addr_nx_s;
         int_src    <= src_nx_s;
         int_idx    <= idx_nx_s;
         in_service <= svc_nx_s;
      end
   end

endmodule
